// File: rtl/galois_lfsr_16bit_checker.sv
// PRBS checker for the 16-bit Galois LFSR: self-seeds from the stream, locks, then counts mismatches.
// Optional GALOIS_CHK_SYNDROME_EN adds err_syndrome (expected ^ data_in of the last locked mismatch).
module galois_lfsr_16bit_checker #(
    parameter logic [15:0] TAPS     = 16'hB400,
    parameter int          LOCK_CNT = 4,
    parameter int          LOSS_CNT = 8,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
`ifdef GALOIS_CHK_SYNDROME_EN
    ,
    output logic [15:0]      err_syndrome
`endif
);

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [7:0]       LOSS_TGT = 8'(LOSS_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    state_t           r_state;
    logic [15:0]      r_expected;
    logic             r_have_seed;
    logic [3:0]       r_run;
    logic [7:0]       r_miss;
    logic             r_locked;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_word_count;

    logic [15:0]      w_next_in;
    logic [15:0]      w_next_exp;
    logic             w_match;
    logic [3:0]       w_run_inc;
    logic [7:0]       w_miss_inc;
    logic             w_word_evt;
    logic             w_err_evt;
    logic [CNT_W-1:0] w_err_count_next;
    logic [CNT_W-1:0] w_word_count_next;

    assign w_next_in  = lfsr_next(data_in);
    assign w_next_exp = lfsr_next(r_expected);
    assign w_match    = (data_in == r_expected);
    assign w_run_inc  = r_run + 4'd1;
    assign w_miss_inc = r_miss + 8'd1;
    assign w_word_evt = data_valid && (r_state == ST_LOCKED);
    assign w_err_evt  = w_word_evt && !w_match;

    // Clear wins over the old value but still admits this cycle's event.
    always_comb begin
        w_err_count_next  = r_err_count;
        w_word_count_next = r_word_count;
        if (clr_cnt) begin
            w_err_count_next  = w_err_evt  ? CNT_ONE : '0;
            w_word_count_next = w_word_evt ? CNT_ONE : '0;
        end else begin
            if (w_err_evt && !(&r_err_count))
                w_err_count_next = r_err_count + CNT_ONE;
            if (w_word_evt && !(&r_word_count))
                w_word_count_next = r_word_count + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state      <= ST_SEARCH;
            r_expected   <= 16'h0000;
            r_have_seed  <= 1'b0;
            r_run        <= 4'd0;
            r_miss       <= 8'd0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            r_err_pulse  <= 1'b0;
            r_err_count  <= w_err_count_next;
            r_word_count <= w_word_count_next;
            if (data_valid) begin
                case (r_state)
                    ST_SEARCH: begin
                        if (data_in == 16'h0000) begin
                            r_have_seed <= 1'b0;
                            r_run       <= 4'd0;
                        end else if (!r_have_seed || !w_match) begin
                            r_expected  <= w_next_in;
                            r_have_seed <= 1'b1;
                            r_run       <= 4'd0;
                        end else begin
                            r_expected <= w_next_in;
                            r_run      <= w_run_inc;
                            if (w_run_inc == LOCK_TGT) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                                r_miss   <= 8'd0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // Free-running prediction: a single bad word costs exactly one error.
                        r_expected <= w_next_exp;
                        if (w_match) begin
                            r_miss <= 8'd0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_miss      <= w_miss_inc;
                            if (w_miss_inc == LOSS_TGT) begin
                                r_state     <= ST_SEARCH;
                                r_locked    <= 1'b0;
                                r_have_seed <= 1'b0;
                                r_run       <= 4'd0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef GALOIS_CHK_SYNDROME_EN
    logic [15:0] r_syndrome;
    always_ff @(posedge CLK) begin
        if (rst)
            r_syndrome <= 16'h0000;
        else if (w_err_evt)
            r_syndrome <= r_expected ^ data_in;
        else if (clr_cnt)
            r_syndrome <= 16'h0000;
    end
    assign err_syndrome = r_syndrome;
`endif

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_galois_lfsr_16bit_checker.sv
// Bench for galois_lfsr_16bit_checker: directed scenarios plus random stream against a reference model.
// Drives a CNT_W=32 and a CNT_W=4 instance with identical stimulus.
module tb_galois_lfsr_16bit_checker;

    localparam logic [15:0] TAPS = 16'hB400;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 8;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        data_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [31:0] err_count, word_count;
    logic [3:0]  err_count4, word_count4;
`ifdef GALOIS_CHK_SYNDROME_EN
    logic [15:0] err_syndrome, err_syndrome4;
`endif

    always #5 CLK = ~CLK;

    galois_lfsr_16bit_checker #(.TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(32)) u_dut (
        .CLK(CLK), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
`ifdef GALOIS_CHK_SYNDROME_EN
        , .err_syndrome(err_syndrome)
`endif
    );

    galois_lfsr_16bit_checker #(.TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .word_count(word_count4)
`ifdef GALOIS_CHK_SYNDROME_EN
        , .err_syndrome(err_syndrome4)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks what the checker believes about the stream.
    bit          m_locked, m_seed, m_pulse;
    logic [15:0] m_exp, m_syn;
    int          m_run, m_miss;
    longint      m_err, m_word, m_err4, m_word4;
    logic [15:0] g;

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return (s / 2) ^ ((s % 2) != 0 ? TAPS : 16'h0000);
    endfunction

    function automatic longint sat_inc(input longint v, input longint max_v);
        return (v < max_v) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_seed = 0; m_pulse = 0; m_exp = 0; m_syn = 0;
        m_run = 0; m_miss = 0; m_err = 0; m_word = 0; m_err4 = 0; m_word4 = 0;
    endtask

    task automatic model_step(input logic [15:0] w, input bit v, input bit c);
        m_pulse = 0;
        if (c) begin
            m_err = 0; m_word = 0; m_err4 = 0; m_word4 = 0; m_syn = 0;
        end
        if (v && !m_locked) begin
            if (w == 0) begin
                m_seed = 0; m_run = 0;
            end else if (!m_seed || w != m_exp) begin
                m_exp = nxt(w); m_seed = 1; m_run = 0;
            end else begin
                m_exp = nxt(w); m_run++;
                if (m_run == LOCK_CNT) begin m_locked = 1; m_miss = 0; end
            end
        end else if (v) begin
            m_word  = sat_inc(m_word, 64'hFFFF_FFFF);
            m_word4 = sat_inc(m_word4, 15);
            if (w != m_exp) begin
                m_pulse = 1;
                m_err   = sat_inc(m_err, 64'hFFFF_FFFF);
                m_err4  = sat_inc(m_err4, 15);
                m_syn   = w ^ m_exp;
                m_miss++;
                if (m_miss == LOSS_CNT) begin m_locked = 0; m_seed = 0; m_run = 0; end
            end else begin
                m_miss = 0;
            end
            m_exp = nxt(m_exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_locked"}, 32'(locked), 32'(m_locked));
        check_val({tag, "_pulse"},  32'(err_pulse), 32'(m_pulse));
        check_val({tag, "_errcnt"}, err_count, 32'(m_err));
        check_val({tag, "_wrdcnt"}, word_count, 32'(m_word));
        check_val({tag, "_locked4"}, 32'(locked4), 32'(m_locked));
        check_val({tag, "_errcnt4"}, 32'(err_count4), 32'(m_err4));
        check_val({tag, "_wrdcnt4"}, 32'(word_count4), 32'(m_word4));
`ifdef GALOIS_CHK_SYNDROME_EN
        check_val({tag, "_syn"},  32'(err_syndrome), 32'(m_syn));
        check_val({tag, "_syn4"}, 32'(err_syndrome4), 32'(m_syn));
`endif
    endtask

    task automatic drive(input string tag, input logic [15:0] w, input bit v, input bit c);
        data_in = w; data_valid = v; clr_cnt = c;
        model_step(w, v, c);
        @(posedge CLK); #1;
        data_valid = 0; clr_cnt = 0;
        compare_all(tag);
    endtask

    task automatic send(input string tag, input logic [15:0] mask, input bit c);
        drive(tag, g ^ mask, 1, c);
        g = nxt(g);
    endtask

    task automatic send_zero(input string tag);
        drive(tag, 16'h0000, 1, 0);
        g = nxt(g);
    endtask

    task automatic do_reset(input string tag);
        rst = 1; data_valid = 0; clr_cnt = 0;
        @(posedge CLK); #1;
        rst = 0;
        model_reset();
        compare_all(tag);
    endtask

    initial begin
        do_reset("rst0");
        check_val("rst0_locked_const", 32'(locked), 32'd0);
        check_val("rst0_err_const", err_count, 32'd0);

        // Lock onto the stream starting at 16'hACE1.
        g = 16'hACE1;
        for (int i = 0; i < 4; i++) send("t1", 16'h0, 0);
        check_val("t1_not_yet_locked", 32'(locked), 32'd0);
        send("t1", 16'h0, 0);
        check_val("t1_locked", 32'(locked), 32'd1);
        check_val("t1_err0", err_count, 32'd0);
        $display("[TB] txn lock: locked=%0d err_count=%0d", locked, err_count);

        // Single flipped bit.
        for (int i = 0; i < 3; i++) send("t2", 16'h0, 0);
        send("t2", 16'h0001, 0);
        check_val("t2_pulse", 32'(err_pulse), 32'd1);
        check_val("t2_err1", err_count, 32'd1);
        check_val("t2_still_locked", 32'(locked), 32'd1);
`ifdef GALOIS_CHK_SYNDROME_EN
        check_val("t2_syn1", 32'(err_syndrome), 32'h0001);
`endif
        send("t2", 16'h0, 0);
        check_val("t2_no_pulse", 32'(err_pulse), 32'd0);
        check_val("t2_err_hold", err_count, 32'd1);
        $display("[TB] txn bitflip: err_count=%0d locked=%0d", err_count, locked);

        // Eight zero words drop the lock.
        drive("t3_clr", 16'h1234, 0, 1);
        for (int i = 0; i < 7; i++) send_zero("t3");
        check_val("t3_locked_at7", 32'(locked), 32'd1);
        send_zero("t3");
        check_val("t3_err8", err_count, 32'd8);
        check_val("t3_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 4; i++) send("t3r", 16'h0, 0);
        check_val("t3_relock_not_yet", 32'(locked), 32'd0);
        send("t3r", 16'h0, 0);
        check_val("t3_relocked", 32'(locked), 32'd1);
        $display("[TB] txn loss/relock: err_count=%0d locked=%0d", err_count, locked);

        // Valid low for 20 cycles, then resume.
        for (int i = 0; i < 20; i++) drive("t4_hold", 16'($urandom), 0, 0);
        for (int i = 0; i < 3; i++) send("t4_resume", 16'h0, 0);
        check_val("t4_err_frozen", err_count, 32'd8);
        check_val("t4_locked", 32'(locked), 32'd1);
        do_reset("t4_rst");
        check_val("t4_rst_unlocked", 32'(locked), 32'd0);
        check_val("t4_rst_wc0", word_count, 32'd0);
        $display("[TB] txn hold/reset: locked=%0d word_count=%0d", locked, word_count);

        // clr_cnt coincident with a mismatch, then saturation of the narrow counters.
        for (int i = 0; i < 5; i++) send("t5_lock", 16'h0, 0);
        send("t5", 16'h0, 0);
        send("t5_clr", 16'h0100, 1);
        check_val("t5_clr_err1", err_count, 32'd1);
        for (int i = 0; i < 20; i++) begin
            send("t5_sat", 16'h8000, 0);
            send("t5_sat", 16'h0, 0);
        end
        check_val("t5_sat4", 32'(err_count4), 32'hF);
        check_val("t5_err21", err_count, 32'd21);
        $display("[TB] txn clr/sat: err_count=%0d err_count4=%0d", err_count, err_count4);

        // Randomised stream with corruption, zero words, gaps, clears and resyncs.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 80) drive("rnd_idle", 16'($urandom), 0, r < 5);
            else if (r < 110) send_zero("rnd_zero");
            else if (r < 200) send("rnd_bad", 16'($urandom_range(1, 65535)), r < 120);
            else if (r < 203) begin
                g = 16'($urandom_range(1, 65535));
                send("rnd_jump", 16'h0, 0);
            end else send("rnd_ok", 16'h0, r < 215);
        end
        $display("[TB] txn random: err_count=%0d word_count=%0d", err_count, word_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
